ram_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the team's 64x8 single-port synchronous RAM (registered read address, write-enable-gated).
- Each requester issues one read or write at a time with a req/ack handshake.
- The arbiter drives the RAM's we/addr/data_in and returns read data.
- Sits at top level beside the RAM instance, between two bus masters (e.g. CPU port and DMA port) and the memory.

---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_arbiter_if.sv | 36 +++
 rtl/ram_arbiter_rr_arb2.sv | 14 +
 rtl/ram_arbiter.sv | 125 ++++++++++++
 tb/tb_ram_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared widths and FSM encoding for the two-port RAM arbiter.
package ram_pkg;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 8;
  localparam int RAM_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } arbState_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester handshakes plus the RAM command/return bus around the arbiter.
interface ram_arbiter_if;
  import ram_pkg::*;

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  // master = requesters together with the RAM; slave = the arbiter itself
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  ack0, rdata0, ack1, rdata1, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output ack0, rdata0, ack1, rdata1, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on contention the requester that
// was not granted last time wins.
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic winner_o,
  output logic valid_o
);

  assign valid_o  = req0_i | req1_i;
  assign winner_o = (req0_i & req1_i) ? ~last_grant_i : req1_i;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer in front of a 64x8 single-port synchronous RAM.
// Each transaction runs IDLE -> ISSUE -> READ -> DONE with registered outputs.
module ram_arbiter
  import ram_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave bus
);

  arbState_e         state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              is_write_q, is_write_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              busy_q, busy_d;

  logic pickWinner;
  logic pickValid;

  rr_arb2 u_pick (
    .req0_i       (bus.req0),
    .req1_i       (bus.req1),
    .last_grant_i (last_grant_q),
    .winner_o     (pickWinner),
    .valid_o      (pickValid)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    is_write_d   = is_write_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ack0_d       = ack0_q;
    ack1_d       = ack1_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      IDLE: begin
        mem_we_d = 1'b0;
        if (pickValid) begin
          owner_d      = pickWinner;
          last_grant_d = pickWinner;
          is_write_d   = pickWinner ? bus.we1 : bus.we0;
          mem_we_d     = pickWinner ? bus.we1 : bus.we0;
          mem_addr_d   = pickWinner ? bus.addr1 : bus.addr0;
          mem_wdata_d  = pickWinner ? bus.wdata1 : bus.wdata0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        mem_we_d = 1'b0;
        state_d  = READ;
      end
      READ: begin
        // RAM output reflects the address latched at the end of ISSUE
        if (!is_write_q) begin
          if (owner_q) rdata1_d = bus.mem_rdata;
          else         rdata0_d = bus.mem_rdata;
        end
        if (owner_q) ack1_d = 1'b1;
        else         ack0_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      is_write_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      is_write_q   <= is_write_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, array memory model and round-robin
// grant model, directed steps plus randomized contention traffic.
module tb_ram_arbiter;
  import ram_pkg::*;

  logic clk;
  logic rst;
  logic ramClear;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // behavioural 64x8 RAM with registered read address
  logic [DATA_W-1:0] ramArr [RAM_DEPTH];
  logic [ADDR_W-1:0] ramRaddr;

  always @(posedge clk) begin
    if (ramClear) begin
      for (int i = 0; i < RAM_DEPTH; i++) ramArr[i] <= '0;
    end else begin
      if (bus.mem_we) ramArr[bus.mem_addr] <= bus.mem_wdata;
      ramRaddr <= bus.mem_addr;
    end
  end

  assign bus.mem_rdata = ramArr[ramRaddr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int weCycles = 0;
  always @(negedge clk) if (bus.mem_we === 1'b1) weCycles++;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] refMem [RAM_DEPTH];
  logic [DATA_W-1:0] refRd  [2];
  int                lastW;

  logic              pend [2];
  logic              pw   [2];
  logic [ADDR_W-1:0] pa   [2];
  logic [DATA_W-1:0] pd   [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req0 = pend[0]; bus.we0 = pw[0]; bus.addr0 = pa[0]; bus.wdata0 = pd[0];
    bus.req1 = pend[1]; bus.we1 = pw[1]; bus.addr1 = pa[1]; bus.wdata1 = pd[1];
  endtask

  task automatic modelReset();
    lastW    = 1;
    refRd[0] = '0;
    refRd[1] = '0;
  endtask

  // Wait for the next ack and compare grant, latency, write strobe and read data
  task automatic serveOne(input int expLat, output int who);
    int exp;
    int cyc;
    int got;
    int weStart;
    exp     = (pend[0] && pend[1]) ? ((lastW == 0) ? 1 : 0) : (pend[0] ? 0 : 1);
    weStart = weCycles;
    cyc     = 0;
    got     = -1;
    while (got < 0 && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (bus.ack0 === 1'b1) got = 0;
      else if (bus.ack1 === 1'b1) got = 1;
    end
    check("ack_seen", (got >= 0), 1);
    who = got;
    if (got < 0) return;
    check("grant", got, exp);
    check("latency", cyc, expLat);
    check("ack_exclusive", bus.ack0 & bus.ack1, 0);
    check("busy_done", bus.busy, 1);
    check("we_cycles", weCycles - weStart, pw[got] ? 1 : 0);
    lastW = got;
    if (pw[got]) refMem[pa[got]] = pd[got];
    else         refRd[got]      = refMem[pa[got]];
    check("rdata0", bus.rdata0, refRd[0]);
    check("rdata1", bus.rdata1, refRd[1]);
  endtask

  task automatic singleTxn(input int who, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    int got;
    pend[who] = 1'b1; pw[who] = w; pa[who] = a; pd[who] = d;
    drive();
    serveOne(3, got);
    pend[who] = 1'b0;
    drive();
    @(negedge clk);
    check("ack_cleared", {bus.ack0, bus.ack1}, 0);
    check("busy_idle", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    rst      = 1'b1;
    ramClear = 1'b1;
    for (int i = 0; i < RAM_DEPTH; i++) refMem[i] = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; pw[i] = 1'b0; pa[i] = '0; pd[i] = '0;
    end
    modelReset();
    drive();
    repeat (3) @(negedge clk);

    // reset state
    check("rst_ack", {bus.ack0, bus.ack1}, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_rdata", {bus.rdata0, bus.rdata1}, 0);
    ramClear = 1'b0;
    rst      = 1'b0;
    @(negedge clk);

    // single requester write then read back
    singleTxn(0, 1'b1, 6'h05, 8'hA5);
    singleTxn(0, 1'b0, 6'h05, 8'h00);
    check("t1_rdata0", bus.rdata0, 8'hA5);

    // reset during ISSUE of a write aborts it
    pend[0] = 1'b1; pw[0] = 1'b1; pa[0] = 6'h08; pd[0] = 8'h77;
    drive();
    @(negedge clk);
    check("abort_we_issue", bus.mem_we, 1);
    rst = 1'b1;
    #1;
    check("abort_we_drop", bus.mem_we, 0);
    check("abort_busy_drop", bus.busy, 0);
    check("abort_ack", {bus.ack0, bus.ack1}, 0);
    pend[0] = 1'b0;
    drive();
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    @(negedge clk);
    check("abort_no_ack", {bus.ack0, bus.ack1}, 0);
    singleTxn(0, 1'b0, 6'h08, 8'h00);
    check("abort_ram_kept", bus.rdata0, 8'h00);

    // simultaneous requests after reset: requester 0 first
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    modelReset();
    pend[0] = 1'b1; pw[0] = 1'b1; pa[0] = 6'h10; pd[0] = 8'h11;
    pend[1] = 1'b1; pw[1] = 1'b1; pa[1] = 6'h20; pd[1] = 8'h22;
    drive();
    serveOne(3, got);
    check("sim_first", got, 0);
    pend[0] = 1'b0;
    drive();
    serveOne(4, got);
    check("sim_second", got, 1);
    pend[1] = 1'b0;
    drive();
    @(negedge clk);
    singleTxn(0, 1'b0, 6'h10, 8'h00);
    check("sim_rd0", bus.rdata0, 8'h11);
    singleTxn(1, 1'b0, 6'h20, 8'h00);
    check("sim_rd1", bus.rdata1, 8'h22);

    // address extremes
    singleTxn(0, 1'b1, 6'h3F, 8'hFF);
    singleTxn(1, 1'b1, 6'h00, 8'h01);
    singleTxn(0, 1'b0, 6'h3F, 8'h00);
    check("bnd_top", bus.rdata0, 8'hFF);
    singleTxn(1, 1'b0, 6'h00, 8'h00);
    check("bnd_bottom", bus.rdata1, 8'h01);

    // read-after-write across requesters
    singleTxn(0, 1'b0, 6'h05, 8'h00);
    singleTxn(0, 1'b1, 6'h2A, 8'h5C);
    singleTxn(1, 1'b0, 6'h2A, 8'h00);
    check("raw_rd1", bus.rdata1, 8'h5C);
    check("raw_rd0_kept", bus.rdata0, 8'hA5);

    // continuous requester 1 reads of 0x3F, requester 0 joins with random traffic
    singleTxn(1, 1'b1, 6'h3F, 8'hC3);
    pend[1] = 1'b1; pw[1] = 1'b0; pa[1] = 6'h3F; pd[1] = 8'h00;
    drive();
    serveOne(3, got);
    serveOne(4, got);
    pend[0] = 1'b1;
    pw[0]   = 1'($urandom_range(0, 1));
    pa[0]   = 6'($urandom_range(0, 62));
    pd[0]   = 8'($urandom);
    drive();
    for (int i = 0; i < 20; i++) begin
      serveOne(4, got);
      check("alternate", got, (i % 2 == 0) ? 0 : 1);
      if (got == 0) begin
        pw[0] = 1'($urandom_range(0, 1));
        pa[0] = 6'($urandom_range(0, 62));
        pd[0] = 8'($urandom);
        drive();
      end
    end
    check("cont_rd1", bus.rdata1, 8'hC3);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive();
    repeat (6) @(negedge clk);
    check("final_idle", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
